// File: rtl/pen_plotter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pen_plotter_pkg
// Description : Shared frame geometry, packet constants and the edge packer
//               state encoding for the pen-plotter edge pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package pen_plotter_pkg;

    localparam int H_RES        = 170;
    localparam int V_RES        = 240;
    localparam int EDGE_TH      = 128;
    localparam int FRAME_PIXELS = H_RES * V_RES;
    localparam int BITMAP_BYTES = FRAME_PIXELS / 8;

    localparam logic [7:0] HDR0_BYTE = 8'hA5;
    localparam logic [7:0] HDR1_BYTE = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_HDR0    = 3'd2,
        ST_HDR1    = 3'd3,
        ST_RD      = 3'd4,
        ST_PAY     = 3'd5,
        ST_CKSUM   = 3'd6,
        ST_DONE    = 3'd7
    } packer_state_t;

    function automatic logic is_edge(input logic [7:0] px, input logic [7:0] th);
        return (px >= th);
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_bitmap_ram.sv
`default_nettype none
// ============================================================================
// Module      : edge_bitmap_ram
// Description : Simple dual-port byte RAM holding one packed edge bitmap;
//               synchronous write, one-cycle registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_bitmap_ram #(
    parameter int DEPTH  = pen_plotter_pkg::BITMAP_BYTES,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data
);

    logic [7:0] r_mem [0:DEPTH-1];
    logic [7:0] r_rd_data;

    // Read data only moves on a read strobe, so it doubles as the payload
    // holding register while the consumer is stalled.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/edge_tx_packer.sv
`default_nettype none
// ============================================================================
// Module      : edge_tx_packer
// Description : Thresholds edge pixels to 1 bit, packs a frame into a bitmap
//               buffer, then drains it as a framed packet (A5 5A data XOR).
// Revision    : 1.0 - initial release
// ============================================================================
module edge_tx_packer #(
    parameter int H_RES   = pen_plotter_pkg::H_RES,
    parameter int V_RES   = pen_plotter_pkg::V_RES,
    parameter int EDGE_TH = pen_plotter_pkg::EDGE_TH
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_de,
    input  logic [7:0] i_data,
    input  logic       i_tx_full,
    output logic [7:0] o_tx_data,
    output logic       o_push,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_overrun
);

    import pen_plotter_pkg::*;

    localparam int c_frame_pixels = H_RES * V_RES;
    localparam int c_bitmap_bytes = c_frame_pixels / 8;
    localparam int c_addr_w       = $clog2(c_bitmap_bytes);
    localparam int c_pix_w        = $clog2(c_frame_pixels + 1);

    localparam logic [c_pix_w-1:0]  c_last_pix  = c_pix_w'(c_frame_pixels - 1);
    localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(c_bitmap_bytes - 1);
    localparam logic [7:0]          c_edge_th   = 8'(EDGE_TH);

    packer_state_t r_state;
    packer_state_t w_next;

    logic [c_pix_w-1:0]  r_pix_cnt;
    logic [6:0]          r_shift;
    logic [c_addr_w-1:0] r_wr_addr;
    logic [c_addr_w-1:0] r_rd_addr;
    logic [7:0]          r_cksum;
    logic                r_overrun;

    logic                w_capture;
    logic                w_push;
    logic                w_rd_en;
    logic                w_frame_done;
    logic [7:0]          w_tx_data;
    logic                w_bit;
    logic                w_last_pix;
    logic                w_wr_en;
    logic [7:0]          w_wr_data;
    logic [7:0]          w_rd_data;

    assign w_bit      = is_edge(i_data, c_edge_th);
    assign w_last_pix = (r_pix_cnt == c_last_pix);
    assign w_wr_en    = w_capture && (r_pix_cnt[2:0] == 3'd7);
    assign w_wr_data  = {r_shift, w_bit};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_capture    = 1'b0;
        w_push       = 1'b0;
        w_rd_en      = 1'b0;
        w_frame_done = 1'b0;
        w_tx_data    = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (i_de) begin
                    w_capture = 1'b1;
                    w_next    = w_last_pix ? ST_HDR0 : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (i_de) begin
                    w_capture = 1'b1;
                    if (w_last_pix) begin
                        w_next = ST_HDR0;
                    end
                end
            end
            ST_HDR0: begin
                w_tx_data = HDR0_BYTE;
                if (!i_tx_full) begin
                    w_push = 1'b1;
                    w_next = ST_HDR1;
                end
            end
            ST_HDR1: begin
                w_tx_data = HDR1_BYTE;
                if (!i_tx_full) begin
                    w_push = 1'b1;
                    w_next = ST_RD;
                end
            end
            ST_RD: begin
                w_rd_en = 1'b1;
                w_next  = ST_PAY;
            end
            ST_PAY: begin
                w_tx_data = w_rd_data;
                if (!i_tx_full) begin
                    w_push = 1'b1;
                    w_next = (r_rd_addr == c_last_addr) ? ST_CKSUM : ST_RD;
                end
            end
            ST_CKSUM: begin
                w_tx_data = r_cksum;
                if (!i_tx_full) begin
                    w_push = 1'b1;
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_frame_done = 1'b1;
                w_next       = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pix_cnt <= '0;
            r_shift   <= '0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_cksum   <= 8'h00;
            r_overrun <= 1'b0;
        end else begin
            if (w_capture) begin
                r_pix_cnt <= r_pix_cnt + c_pix_w'(1);
                r_shift   <= {r_shift[5:0], w_bit};
            end
            if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + c_addr_w'(1);
            end
            if (w_push && (r_state == ST_PAY)) begin
                r_cksum   <= r_cksum ^ w_rd_data;
                r_rd_addr <= r_rd_addr + c_addr_w'(1);
            end
            if (r_state == ST_DONE) begin
                r_pix_cnt <= '0;
                r_shift   <= '0;
                r_wr_addr <= '0;
                r_rd_addr <= '0;
                r_cksum   <= 8'h00;
            end
            // Pixels arriving while the buffer is draining cannot be stored.
            if (i_de && (r_state != ST_IDLE) && (r_state != ST_CAPTURE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    edge_bitmap_ram #(
        .DEPTH  (c_bitmap_bytes),
        .ADDR_W (c_addr_w)
    ) u_bitmap_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign o_tx_data    = w_tx_data;
    assign o_push       = w_push;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_frame_done = w_frame_done;
    assign o_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_edge_tx_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_tx_packer
// Description : Directed self-checking bench for edge_tx_packer on a reduced
//               18x8 frame (18 payload bytes, line length not a multiple of 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_tx_packer;

    localparam int c_h    = 18;
    localparam int c_v    = 8;
    localparam int c_npix = c_h * c_v;
    localparam int c_nb   = c_npix / 8;

    logic       clk       = 1'b0;
    logic       rstn      = 1'b0;
    logic       i_de      = 1'b0;
    logic [7:0] i_data    = 8'h00;
    logic       i_tx_full = 1'b0;
    logic [7:0] o_tx_data;
    logic       o_push;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_overrun;

    int         n_checks   = 0;
    int         n_errors   = 0;
    int         done_cnt   = 0;
    int         stall_push = 0;
    bit         full_rand  = 1'b0;
    logic [7:0] got [$];

    edge_tx_packer #(
        .H_RES   (c_h),
        .V_RES   (c_v),
        .EDGE_TH (128)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_de         (i_de),
        .i_data       (i_data),
        .i_tx_full    (i_tx_full),
        .o_tx_data    (o_tx_data),
        .o_push       (o_push),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        i_tx_full = full_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(negedge clk) begin
        if (o_push) got.push_back(o_tx_data);
        if (o_push && i_tx_full) stall_push++;
        if (o_frame_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int mode, input int k);
        case (mode)
            0:       return 8'd255;
            1:       return (k % 8 == 0) ? 8'd200 : 8'd0;
            2:       return (k % 8 == 0) ? 8'd128 : 8'd127;
            3:       return (k == c_h - 1) ? 8'd255 : 8'd0;
            4:       return 8'((k * 73 + 29) % 256);
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input int mode, input int b);
        logic [7:0] r = 8'h00;
        for (int j = 0; j < 8; j++) r[7-j] = (pix(mode, b * 8 + j) >= 8'd128);
        return r;
    endfunction

    function automatic logic [7:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 8'hEE;
    endfunction

    task automatic send_pixels(input int mode, input int count, input bit gaps);
        for (int k = 0; k < count; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    i_de = 1'b0;
                end
            end
            @(posedge clk); #1;
            i_de   = 1'b1;
            i_data = pix(mode, k);
        end
        @(posedge clk); #1;
        i_de = 1'b0;
    endtask

    task automatic check_packet(input int mode, input string tag);
        logic [7:0] e;
        logic [7:0] ck = 8'h00;
        int         bad = 0;
        int         first = -1;
        check({tag, "_len"}, got.size(), c_nb + 3);
        check({tag, "_hdr0"}, got_at(0), 8'hA5);
        check({tag, "_hdr1"}, got_at(1), 8'h5A);
        for (int b = 0; b < c_nb; b++) begin
            e  = exp_byte(mode, b);
            ck = ck ^ e;
            if (got_at(b + 2) !== e) begin
                bad++;
                if (first < 0) first = b;
            end
        end
        check({tag, "_payload_bad"}, bad, 0);
        if (first >= 0) check({tag, "_first_bad_byte"}, got_at(first + 2), exp_byte(mode, first));
        check({tag, "_cksum"}, got_at(c_nb + 2), ck);
    endtask

    task automatic run_frame(input int mode, input bit gaps, input bit poke, input string tag);
        int start;
        got.delete();
        start = done_cnt;
        send_pixels(mode, c_npix, gaps);
        if (!full_rand) begin
            @(negedge clk);
            check({tag, "_hdr_latency"}, {23'd0, o_push, o_tx_data}, {23'd0, 1'b1, 8'hA5});
        end
        if (poke) begin
            repeat (6) @(posedge clk);
            #1;
            i_de   = 1'b1;
            i_data = 8'd255;
            @(posedge clk); #1;
            i_de = 1'b0;
        end
        for (int i = 0; i < 2000 && done_cnt == start; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, done_cnt - start, 1);
        check({tag, "_idle_after"}, o_busy, 1'b0);
        check_packet(mode, tag);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_push", o_push, 1'b0);
        check("rst_tx_data", o_tx_data, 8'h00);
        check("rst_busy", o_busy, 1'b0);
        check("rst_frame_done", o_frame_done, 1'b0);
        check("rst_overrun", o_overrun, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        run_frame(0, 1'b0, 1'b0, "all_ff");
        check("all_ff_byte0", got_at(2), 8'hFF);
        check("all_ff_cksum_hand", got_at(c_nb + 2), 8'h00);

        run_frame(1, 1'b0, 1'b0, "every8th");
        check("every8th_byte5", got_at(7), 8'h80);
        check("every8th_cksum_hand", got_at(c_nb + 2), 8'h00);

        run_frame(2, 1'b0, 1'b0, "th_boundary");
        check("th_boundary_byte0", got_at(2), 8'h80);

        run_frame(3, 1'b0, 1'b0, "line_end");
        check("line_end_byte2", got_at(4), 8'h40);
        check("line_end_byte1", got_at(3), 8'h00);
        check("line_end_cksum_hand", got_at(c_nb + 2), 8'h40);

        full_rand  = 1'b1;
        stall_push = 0;
        run_frame(4, 1'b1, 1'b0, "stalled");
        full_rand = 1'b0;
        check("stalled_push_while_full", stall_push, 0);
        check("overrun_clean", o_overrun, 1'b0);

        run_frame(4, 1'b0, 1'b1, "overrun_frame");
        check("overrun_set", o_overrun, 1'b1);
        run_frame(1, 1'b0, 1'b0, "after_overrun");
        check("overrun_sticky", o_overrun, 1'b1);

        send_pixels(0, 100, 1'b0);
        check("midframe_busy", o_busy, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_overrun", o_overrun, 1'b0);
        check("midrst_push", o_push, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        got.delete();
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_push", got.size(), 0);
        run_frame(3, 1'b0, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_tx_packer.md
# edge_tx_packer

Downstream stage of the Canny edge filter and upstream of the UART TX FIFO. Thresholds each edge pixel to one bit, packs a full 170x240 frame MSB-first into a 5100-byte bitmap buffer at stream rate, then drains the buffer as a framed byte packet (header, payload, XOR checksum) under the FIFO's full flag. Removes the per-pixel FIFO overflow of the direct stream-to-UART path.

## Interface
- H_RES, 170, pixels per line
- V_RES, 240, lines per frame
- EDGE_TH, 128, pixel is edge when i_data >= EDGE_TH
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- i_de  in  1  pixel valid from edge filter
- i_data  in  8  edge pixel value (R channel)
- i_tx_full  in  1  UART TX FIFO full
- o_tx_data  out  8  byte to FIFO, valid while o_push high
- o_push  out  1  FIFO push strobe
- o_busy  out  1  frame capture or transmit in progress
- o_frame_done  out  1  one-cycle pulse after checksum byte pushed
- o_overrun  out  1  sticky: i_de seen while not capturing

## Operation
- States: IDLE, CAPTURE, HDR0, HDR1, RD, PAY, CKSUM, DONE.
- IDLE: pix_cnt=0; first i_de -> CAPTURE, that pixel is captured.
- CAPTURE: per i_de, shift bit (i_data >= EDGE_TH) into byte; 1st pixel of byte lands in bit 7. Every 8th pixel write byte to bitmap at wr_addr, wr_addr++. Packing runs linearly across line boundaries (170 not a multiple of 8). Pixel 40800 (40800/8 = 5100 bytes exact) -> HDR0; no partial byte exists.
- HDR0 pushes 8'hA5, HDR1 pushes 8'h5A, then RD.
- RD: issue bitmap read at rd_addr -> PAY next cycle (1-cycle RAM latency).
- PAY: byte from RAM held in register; push when !i_tx_full; checksum ^= byte; rd_addr++; rd_addr==5099 pushed -> CKSUM else -> RD.
- CKSUM pushes XOR of all 5100 payload bytes -> DONE.
- DONE: pulse o_frame_done, clear counters/checksum -> IDLE.
- i_de outside IDLE/CAPTURE: pixel dropped, o_overrun set; cleared only by rstn.
- o_busy = state != IDLE.

## Timing
- Reset (async, rstn low): state IDLE, all counters 0, checksum 0, o_push 0, o_tx_data 8'h00, o_busy 0, o_frame_done 0, o_overrun 0.
- o_push combinational: high exactly when state in {HDR0, HDR1, PAY, CKSUM} and !i_tx_full; state advances on that edge. i_tx_full high stalls indefinitely, with o_tx_data held stable.
- o_tx_data registered/muxed from state; valid the whole cycle o_push is high.
- Payload throughput: one byte per 2 cycles max (RD+PAY). Headers/checksum: one per cycle when not full.
- Capture accepts one pixel per cycle, no backpressure to upstream; gaps in i_de allowed anywhere.
- Last capture pixel to first header push: 1 cycle.
- rstn asserted mid-frame: partial frame discarded; no push until next full frame.

## Structure
- Shared package pen_plotter_pkg: H_RES/V_RES defaults, FRAME_PIXELS, BITMAP_BYTES (5100), HDR0_BYTE/HDR1_BYTE constants, packer state enum typedef.
- Sub-module edge_bitmap_ram: simple dual-port 5100x8, sync write, 1-cycle registered read, no reset on array.

## Test plan
- All 40800 pixels i_data=255, i_tx_full=0 -> A5, 5A, 5100x FF, checksum 00; o_frame_done one pulse; 5103 pushes total.
- Pixel k = (k%8==0 ? 200 : 0) -> every payload byte 8'h80, checksum 00 (even count); EDGE_TH=128 boundary: i_data=127 -> 0, 128 -> 1.
- Single edge at pixel 169 (last of line 0) -> payload byte 21 = 8'h40, others 00, checksum 8'h40.
- i_tx_full toggled pseudo-randomly 50% -> no push while full, identical byte sequence to unstalled run.
- i_de pulse during PAY -> o_overrun=1, payload unchanged; stays 1 through next frame until rstn.
- rstn low after 20000 captured pixels, then full frame -> exactly one packet, matching clean-frame reference.
